vga_rect_fill: RTL and testbench
================================

# vga_rect_fill

Rectangle-fill engine that sits directly upstream of the VGA framebuffer write port. It accepts fill commands (origin, size, colour) over a valid/ready handshake and streams one framebuffer write per clock, in row-major order, onto `write_enable` / `write_addr` / `write_pixel`. These outputs connect straight to the VGA block's `write_enable` / `write_addr` / `pixel_in`.

## Interface

Parameters:
- `H_VISIBLE_AREA`, default 640: framebuffer width in pixels; must match the VGA instance.
- `V_VISIBLE_AREA`, default 480: framebuffer height in pixels; must match the VGA instance.
- `PIXEL_WIDTH`, default 12: colour width (RED+GREEN+BLUE widths of the VGA instance).
- Derived: `MEM_SIZE = H_VISIBLE_AREA*V_VISIBLE_AREA`, `AW = $clog2(MEM_SIZE)`, `XW = $clog2(H_VISIBLE_AREA+1)`, `YW = $clog2(V_VISIBLE_AREA+1)`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high iff state is IDLE.
- `cmd_x`  in  XW  left column.
- `cmd_y`  in  YW  top row.
- `cmd_w`  in  XW  width in pixels (0 is legal).
- `cmd_h`  in  YW  height in pixels (0 is legal).
- `cmd_color`  in  PIXEL_WIDTH  fill colour.
- `write_enable`  out  1  framebuffer write strobe.
- `write_addr`  out  AW  linear address `row*H_VISIBLE_AREA + col`.
- `write_pixel`  out  PIXEL_WIDTH  colour being written.
- `busy`  out  1  high while in FILL.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation

- States: IDLE, FILL.
- Accept: `cmd_valid && cmd_ready` at a rising edge. Command fields are latched; fields are ignored at all other times.
- Accept with an effective `w==0` or `h==0`:
  - State stays IDLE; no write occurs.
  - `done` pulses the next cycle.
  - `cmd_ready` stays high.
- Accept with a non-empty rectangle:
  - Move to FILL.
  - First write, at `(cmd_x, cmd_y)`, is presented the cycle after the accept edge.
- Pixel walk in FILL:
  - Column counter `c` runs from 0 to w-1, then row counter `r` advances.
  - `write_addr = (y+r)*H_VISIBLE_AREA + x + c`.
  - Row base is kept incrementally: add `H_VISIBLE_AREA` per row, no multiplier in the loop.
  - Exactly `w*h` write cycles, contiguous with no bubbles.
- Completion:
  - At the edge that retires the last pixel: `write_enable` drops to 0, `done` goes to 1 for one cycle, and state returns to IDLE.
  - `cmd_ready` is therefore high in the `done` cycle.
- Arithmetic:
  - Counters are XW/YW bits wide. Address arithmetic is AW bits and truncates on overflow.
  - `write_pixel` holds the latched colour for the whole command and resets to 0.
- `cmd_valid` asserted while busy is not accepted; the command is held by the source until ready.

## Timing

- Reset values:
  - `cmd_ready=1` after release; 0 while `reset` is high.
  - `write_enable=0`, `write_addr=0`, `write_pixel=0`, `busy=0`, `done=0`.
  - State is IDLE.
- All outputs except `cmd_ready` are registered. `cmd_ready` is decoded directly from the state register.
- Latency: accept edge → first write = 1 cycle. Last write → `done` = 1 cycle.
- Back-to-back commands: if the next command is valid in the `done` cycle, it is accepted there. Its first write follows one cycle later, giving a 1-cycle write gap between rectangles.
- Reset mid-FILL: outputs clear immediately (asynchronously). The command is abandoned: no further writes, no `done`.

## Configuration

- `VGA_RECT_CLIP_EN` defined:
  - At accept, `w` is clipped to `H_VISIBLE_AREA - x` and `h` to `V_VISIBLE_AREA - y`.
  - A command with `x >= H_VISIBLE_AREA` or `y >= V_VISIBLE_AREA` is treated as empty (done pulse, no writes).
  - No write ever targets an address `>= MEM_SIZE` or wraps into the next row.
- `VGA_RECT_CLIP_EN` undefined:
  - No clipping. The source guarantees `x+w <= H_VISIBLE_AREA` and `y+h <= V_VISIBLE_AREA`.
  - On violation, addresses follow the plain formula truncated to AW bits. Writes run past the right edge into the next row and past the last row.

## Test plan

All scenarios use the defaults (640x480, 12-bit colour).

1. Basic fill: accept (x=10, y=5, w=3, h=2, color=0xF00).
   - Required: writes of 0xF00 to addresses 3210, 3211, 3212, 3850, 3851, 3852 on 6 consecutive cycles starting 1 cycle after accept.
   - Required: `done` pulses in the 7th cycle and `busy` is low in that cycle.
2. Empty command: accept w=0, h=4.
   - Required: no `write_enable`; `done` pulses the next cycle; `cmd_ready` never drops.
3. Back-to-back: second command (x=0, y=0, w=1, h=1) held valid from cycle 1 of test 1.
   - Required: accepted in the `done` cycle; single write to address 0 exactly one cycle later.
4. Edge clipping: accept (x=638, y=479, w=5, h=3).
   - With `VGA_RECT_CLIP_EN`: exactly 2 writes, to 307198 and 307199, then `done`.
   - Without `VGA_RECT_CLIP_EN`: 15 writes; first 307198; row 2 starts at 307838.
5. Reset mid-fill: assert `reset` after the 3rd write of test 1.
   - Required: `write_enable`, `busy` and `done` go to 0 in the same cycle; no later writes; `cmd_ready=1` after release.
6. Busy backpressure: `cmd_valid` held during FILL.
   - Required: `cmd_ready=0` throughout FILL; the held command is accepted only in the `done` cycle.

Source files
------------

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: streams one framebuffer write per clock to fill a rectangle, row-major.
// Optional edge clipping is enabled by defining VGA_RECT_CLIP_EN.
module vga_rect_fill #(
    parameter int H_VISIBLE_AREA = 640,
    parameter int V_VISIBLE_AREA = 480,
    parameter int PIXEL_WIDTH = 12,
    localparam int MEM_SIZE = H_VISIBLE_AREA * V_VISIBLE_AREA,
    localparam int AW = $clog2(MEM_SIZE),
    localparam int XW = $clog2(H_VISIBLE_AREA + 1),
    localparam int YW = $clog2(V_VISIBLE_AREA + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [XW-1:0]          cmd_x,
    input  logic [YW-1:0]          cmd_y,
    input  logic [XW-1:0]          cmd_w,
    input  logic [YW-1:0]          cmd_h,
    input  logic [PIXEL_WIDTH-1:0] cmd_color,
    output logic                   write_enable,
    output logic [AW-1:0]          write_addr,
    output logic [PIXEL_WIDTH-1:0] write_pixel,
    output logic                   busy,
    output logic                   done
);
    localparam logic IDLE = 1'b0;
    localparam logic FILL = 1'b1;

    logic state;
    logic [XW-1:0] w_l, c, eff_w;
    logic [YW-1:0] h_l, r, eff_h;
    logic [AW-1:0] row_base, start;
    logic empty, last_col, last_row;

    assign cmd_ready = (state == IDLE) && !reset;
    assign start = AW'(cmd_y) * AW'(H_VISIBLE_AREA) + AW'(cmd_x);
    assign last_col = c == w_l - XW'(1);
    assign last_row = r == h_l - YW'(1);

`ifdef VGA_RECT_CLIP_EN
    logic [XW-1:0] x_room;
    logic [YW-1:0] y_room;
    assign x_room = XW'(H_VISIBLE_AREA) - cmd_x;
    assign y_room = YW'(V_VISIBLE_AREA) - cmd_y;
    assign eff_w = cmd_w > x_room ? x_room : cmd_w;
    assign eff_h = cmd_h > y_room ? y_room : cmd_h;
    assign empty = cmd_x >= XW'(H_VISIBLE_AREA) || cmd_y >= YW'(V_VISIBLE_AREA) ||
                   eff_w == '0 || eff_h == '0;
`else
    assign eff_w = cmd_w;
    assign eff_h = cmd_h;
    assign empty = eff_w == '0 || eff_h == '0;
`endif

    // Row base advances by one line per row so the walk needs no multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            w_l          <= '0;
            h_l          <= '0;
            c            <= '0;
            r            <= '0;
            row_base     <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_pixel  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid) begin
                    w_l         <= eff_w;
                    h_l         <= eff_h;
                    c           <= '0;
                    r           <= '0;
                    row_base    <= start;
                    write_addr  <= start;
                    write_pixel <= cmd_color;
                    if (empty) begin
                        done <= 1'b1;
                    end else begin
                        state        <= FILL;
                        busy         <= 1'b1;
                        write_enable <= 1'b1;
                    end
                end
            end else if (last_col) begin
                c <= '0;
                if (last_row) begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    write_enable <= 1'b0;
                    done         <= 1'b1;
                end else begin
                    r          <= r + YW'(1);
                    row_base   <= row_base + AW'(H_VISIBLE_AREA);
                    write_addr <= row_base + AW'(H_VISIBLE_AREA);
                end
            end else begin
                c          <= c + XW'(1);
                write_addr <= write_addr + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: scoreboard bench; expected writes are queued at stimulus and popped by a write monitor.
module tb_vga_rect_fill;
    localparam int H = 640;
    localparam int V = 480;
    localparam int AW = 19;
    localparam int XW = 10;
    localparam int YW = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [XW-1:0] cmd_x = '0;
    logic [YW-1:0] cmd_y = '0;
    logic [XW-1:0] cmd_w = '0;
    logic [YW-1:0] cmd_h = '0;
    logic [11:0] cmd_color = '0;
    logic write_enable;
    logic [AW-1:0] write_addr;
    logic [11:0] write_pixel;
    logic busy, done;

    int vectors = 0;
    int miscompares = 0;
    logic [AW+11:0] sb[$];

    vga_rect_fill dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .write_enable(write_enable), .write_addr(write_addr), .write_pixel(write_pixel),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && write_enable) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: addr=%0d pixel=%h, required no write", write_addr, write_pixel);
            end else begin
                logic [AW+11:0] e;
                e = sb.pop_front();
                if ({write_addr, write_pixel} !== e) begin
                    miscompares++;
                    $display("FAIL write: addr=%0d pixel=%h, required addr=%0d pixel=%h",
                             write_addr, write_pixel, e[AW+11:12], e[11:0]);
                end
            end
        end
    end

    task automatic set_cmd(input int x, input int y, input int w, input int h, input int col);
        cmd_x = XW'(x); cmd_y = YW'(y); cmd_w = XW'(w); cmd_h = YW'(h); cmd_color = 12'(col);
        cmd_valid = 1'b1;
    endtask

    task automatic push_rect(input int x, input int y, input int w, input int h, input int col);
        for (int rr = 0; rr < h; rr++)
            for (int cc = 0; cc < w; cc++)
                sb.push_back({AW'((y + rr) * H + x + cc), 12'(col)});
    endtask

    task automatic check_outs(input string name, input logic we, input logic bz, input logic dn, input logic rdy);
        vectors++;
        if ({write_enable, busy, done, cmd_ready} !== {we, bz, dn, rdy}) begin
            miscompares++;
            $display("FAIL %s: we/busy/done/ready=%b%b%b%b, required %b%b%b%b",
                     name, write_enable, busy, done, cmd_ready, we, bz, dn, rdy);
        end
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d writes outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        #1;
        check_outs("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (write_addr !== '0 || write_pixel !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%0d pixel=%h, required 0 0", write_addr, write_pixel);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("reset_release", 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Basic fill with a second command held valid throughout FILL.
    task automatic test_back_to_back;
        @(negedge clk);
        set_cmd(10, 5, 3, 2, 'hF00);
        push_rect(10, 5, 3, 2, 'hF00);
        @(posedge clk);
        #1;
        set_cmd(0, 0, 1, 1, 'hABC);
        push_rect(0, 0, 1, 1, 'hABC);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_outs($sformatf("fill_cycle%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        check_outs("basic_done", 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_outs("b2b_write", 1'b1, 1'b1, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_outs("b2b_done", 1'b0, 1'b0, 1'b1, 1'b1);
        check_drained("b2b_drain");
    endtask

    task automatic test_empty;
        @(negedge clk);
        set_cmd(20, 20, 0, 4, 'h0F0);
        check_outs("empty_ready", 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_outs("empty_done", 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_outs("empty_after", 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_edge;
        int n, cnt, got_done;
`ifdef VGA_RECT_CLIP_EN
        push_rect(638, 479, 2, 1, 'h00F);
        n = 2;
`else
        push_rect(638, 479, 5, 3, 'h00F);
        n = 15;
`endif
        cnt = 0;
        got_done = 0;
        @(negedge clk);
        set_cmd(638, 479, 5, 3, 'h00F);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < n + 5 && got_done == 0; i++) begin
            @(negedge clk);
            if (write_enable) cnt++;
            if (done) got_done = 1;
        end
        vectors++;
        if (got_done == 0 || cnt != n) begin
            miscompares++;
            $display("FAIL edge_count: writes=%0d done_seen=%0d, required writes=%0d done_seen=1", cnt, got_done, n);
        end
        check_drained("edge_drain");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        set_cmd(10, 5, 3, 2, 'hF00);
        push_rect(10, 5, 3, 1, 'hF00);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_outs("midreset_clear", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("midreset_release", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_outs($sformatf("midreset_idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        check_drained("midreset_drain");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_empty();
        test_edge();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
